noc_output_arbiter: RTL and testbench

- Round-robin arbiter and read sequencer for one router output port.
- Shares the port between the N input-port FIFO buffers: picks a non-empty FIFO, pulses its RD, captures the flit and presents it downstream with a valid/ready handshake.
- Holds the grant for a whole packet, head to tail, so flits of different packets never interleave on the link.
- One instance per output port of the 5-port router.

---
 rtl/noc_output_arbiter.sv | 127 ++++++++++++
 tb/tb_noc_output_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin arbiter and read sequencer for one router
// output port. Picks a non-empty input FIFO, strobes its read, captures the
// flit and drives it downstream over valid/ready.
// Optional feature macro: ARB_PKT_LOCK_EN -- when defined, the grant is held
// from head to tail/single so packets never interleave; when undefined, every
// flit is treated as last and the block re-arbitrates after each one.
module noc_output_arbiter #(
    parameter int N_PORTS = 5,
    parameter int DATA_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          fifo_emp,
    output logic [N_PORTS-1:0]          fifo_rd,
    input  logic [N_PORTS*DATA_W-1:0]   fifo_data,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_PORTS-1:0]          grant,
    output logic                        busy
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, WAIT_FLIT} state_t;

    state_t                          state;
    logic [IDX_W-1:0]                rr_ptr;
    logic [IDX_W-1:0]                owner;
    logic [IDX_W-1:0]                winner;
    logic [IDX_W-1:0]                ptr_next;
    logic                            win_vld;
    logic                            last_flit;
    logic [N_PORTS-1:0]              req;
    logic [N_PORTS-1:0]              win_oh;
    logic [N_PORTS-1:0][DATA_W-1:0]  slice;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_slice
        assign slice[i] = fifo_data[i*DATA_W +: DATA_W];
    end

    assign req      = ~fifo_emp;
    assign win_oh   = N_PORTS'(1) << winner;
    assign ptr_next = (owner == IDX_W'(N_PORTS-1)) ? '0 : owner + 1'b1;
    assign busy     = (state != IDLE);

    // Tail (10) and single (11) both have the type MSB set; without locking
    // every flit closes its own grant.
`ifdef ARB_PKT_LOCK_EN
    assign last_flit = out_data[DATA_W-1];
`else
    assign last_flit = 1'b1;
`endif

    // Round-robin search: first requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        logic [IDX_W:0] idx;
        winner  = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(N_PORTS))
                idx = idx - (IDX_W+1)'(N_PORTS);
            if (!win_vld && req[idx[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                winner  = idx[IDX_W-1:0];
            end
        end
    end

    // Sequencer FSM: grant -> read strobe -> capture -> handshake, per flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fifo_rd   <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner   <= winner;
                        grant   <= win_oh;
                        fifo_rd <= win_oh;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    fifo_rd <= '0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    out_data  <= slice[owner];
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_flit) begin
                            rr_ptr <= ptr_next;
                            grant  <= '0;
                            state  <= IDLE;
                        end else if (!fifo_emp[owner]) begin
                            fifo_rd <= grant;
                            state   <= FETCH;
                        end else begin
                            state <= WAIT_FLIT;
                        end
                    end
                end
                WAIT_FLIT: begin
                    // Lock held: only the owner can resume the packet.
                    if (!fifo_emp[owner]) begin
                        fifo_rd <= grant;
                        state   <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: directed scenarios plus randomized packet traffic
// against a packet-level round-robin reference model.
module tb_noc_output_arbiter;
    localparam int N  = 5;
    localparam int DW = 16;
`ifdef ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      fifo_emp;
    logic [N-1:0]      fifo_rd;
    logic [N*DW-1:0]   fifo_data;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      grant;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    noc_output_arbiter #(.N_PORTS(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .fifo_emp(fifo_emp), .fifo_rd(fifo_rd),
        .fifo_data(fifo_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .grant(grant), .busy(busy)
    );

    // Input FIFO models: registered read port, write side driven by the bench.
    logic [DW-1:0] mem [N][1024];
    int            wp [N] = '{default:0};
    int            rp [N] = '{default:0};
    logic [DW-1:0] dreg [N] = '{default:'0};

    for (genvar i = 0; i < N; i++) begin : g_fifo
        assign fifo_emp[i]           = (wp[i] == rp[i]);
        assign fifo_data[i*DW +: DW] = dreg[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (fifo_rd[i] && wp[i] != rp[i]) begin
                dreg[i] <= mem[i][rp[i] % 1024];
                rp[i]   <= rp[i] + 1;
            end
    end

    // Reference model state.
    logic [DW-1:0] mq [N][$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            ptr_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_raw(input int p, input logic [DW-1:0] d);
        mem[p][wp[p] % 1024] = d;
        wp[p] = wp[p] + 1;
    endtask

    task automatic push(input int p, input logic [DW-1:0] d);
        push_raw(p, d);
        mq[p].push_back(d);
    endtask

    // Serve queued packets round-robin from ptr_m; one flit per grant when
    // locking is off, one whole packet per grant when it is on.
    task automatic model_drain();
        int w;
        bit found;
        logic [DW-1:0] f;
        forever begin
            found = 1'b0;
            w = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && mq[(ptr_m + k) % N].size() > 0) begin
                    w = (ptr_m + k) % N;
                    found = 1'b1;
                end
            end
            if (!found) return;
            do begin
                f = mq[w].pop_front();
                exp_q.push_back(f);
            end while (LOCK && !f[DW-1] && mq[w].size() > 0);
            ptr_m = (w + 1) % N;
        end
    endtask

    // One clock: record accepted flits and check per-cycle invariants.
    task automatic tick();
        logic pv, pr, prst;
        logic [DW-1:0] pd;
        pv = out_valid; pr = out_ready; pd = out_data; prst = rst;
        if (!prst) chk("rd_to_empty", 32'(fifo_rd & fifo_emp), 0);
        @(posedge clk);
        #1;
        if (pv && pr && !prst) got_q.push_back(pd);
        chk("rd_onehot", 32'($countones(fifo_rd) <= 1), 1);
        chk("grant_onehot", 32'($countones(grant) <= 1), 1);
        chk("busy_vs_grant", 32'(busy), 32'(grant != '0));
        chk("rd_outside_grant", 32'(fifo_rd & ~grant), 0);
        if (pv && !pr && !prst) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(pd));
        end
    endtask

    task automatic run_until(input int n, input int budget, input bit rnd);
        int b = 0;
        while (got_q.size() < n && b < budget) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            tick();
            b++;
        end
        chk("flit_timeout", got_q.size(), n);
        out_ready = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        int b = 0;
        while (!out_valid && b < budget) begin
            tick();
            b++;
        end
        chk("wait_valid", 32'(out_valid), 1);
    endtask

    task automatic compare_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_flit"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            wp[i] = rp[i];
            mq[i].delete();
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_rd", 32'(fifo_rd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(out_data), 0);
        flush();
        ptr_m = 0;
        rst = 1'b0;
    endtask

    initial begin
        int seq;
        int npk, len;
        logic [1:0] ty;
        logic [2:0] p3;
        logic [10:0] s11;

        rst = 1'b1;
        out_ready = 1'b0;
        ptr_m = 0;
        do_reset();

        // Single flit from FIFO 2: latency and strobe shape.
        push(2, 16'hC0A5);
        model_drain();
        tick();
        chk("s1_rd", 32'(fifo_rd), 32'b00100);
        chk("s1_grant", 32'(grant), 32'b00100);
        tick();
        chk("s1_rd_off", 32'(fifo_rd), 0);
        chk("s1_valid_early", 32'(out_valid), 0);
        tick();
        chk("s1_valid", 32'(out_valid), 1);
        chk("s1_data", 32'(out_data), 32'hC0A5);
        tick();
        chk("s1_grant_clr", 32'(grant), 0);
        chk("s1_busy", 32'(busy), 0);
        chk("s1_valid_clr", 32'(out_valid), 0);
        compare_q("s1");

        // All five FIFOs with one single flit each.
        do_reset();
        for (int i = 0; i < N; i++) push(i, 16'hC000 + 16'(i));
        model_drain();
        run_until(5, 100, 1'b0);
        compare_q("all5");

        // Multi-flit packet on FIFO 1 racing a single on FIFO 3.
        do_reset();
        push(1, 16'h4001); push(1, 16'h0002); push(1, 16'h8003); push(3, 16'hC033);
        model_drain();
        run_until(4, 100, 1'b0);
        compare_q("pkt");

        // Backpressure: flit held for 4 cycles.
        do_reset();
        push(2, 16'hC0B7);
        model_drain();
        out_ready = 1'b0;
        wait_valid(10);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'hC0B7);
            chk("bp_rd", 32'(fifo_rd), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_done", 32'(out_valid), 0);
        compare_q("bp");

        // Owner runs dry mid-packet while FIFO 4 waits.
        do_reset();
        push_raw(0, 16'h4010);
        push_raw(4, 16'hC444);
        run_until(1, 50, 1'b0);
        repeat (4) tick();
        if (LOCK) begin
            chk("wf_grant", 32'(grant), 32'b00001);
            chk("wf_busy", 32'(busy), 1);
            chk("wf_fifo4_unread", 32'(fifo_emp[4]), 0);
            chk("wf_valid", 32'(out_valid), 0);
        end
        push_raw(0, 16'h8011);
        run_until(3, 80, 1'b0);
        exp_q.push_back(16'h4010);
        if (LOCK) begin
            exp_q.push_back(16'h8011);
            exp_q.push_back(16'hC444);
        end else begin
            exp_q.push_back(16'hC444);
            exp_q.push_back(16'h8011);
        end
        compare_q("wf");

        // Reset in the middle of a packet after moving the pointer off 0.
        do_reset();
        push(2, 16'hC0B0);
        model_drain();
        run_until(1, 50, 1'b0);
        compare_q("mr_pre");
        push_raw(1, 16'h4001); push_raw(1, 16'h0002); push_raw(1, 16'h8003);
        out_ready = 1'b0;
        wait_valid(10);
        rst = 1'b1;
        tick();
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_grant", 32'(grant), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_rd", 32'(fifo_rd), 0);
        flush();
        tick();
        rst = 1'b0;
        ptr_m = 0;
        out_ready = 1'b1;
        push(4, 16'hC0E4);
        push(0, 16'hC0E0);
        model_drain();
        run_until(2, 60, 1'b0);
        compare_q("mr_ptr");

        // Randomized packet traffic with random backpressure.
        seq = 0;
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 4) == 0) do_reset();
            for (int p = 0; p < N; p++) begin
                npk = $urandom_range(0, 2);
                p3 = 3'(p);
                for (int q = 0; q < npk; q++) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) begin
                        if (len == 1)         ty = 2'b11;
                        else if (j == 0)      ty = 2'b01;
                        else if (j == len-1)  ty = 2'b10;
                        else                  ty = 2'b00;
                        s11 = 11'(seq);
                        seq++;
                        push(p, {ty, p3, s11});
                    end
                end
            end
            model_drain();
            run_until(exp_q.size(), exp_q.size() * 20 + 50, 1'b1);
            compare_q("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
